// File: rtl/ad9363_pkg.sv
// Shared definitions for the AD9363 receive-interface delay calibration.
package ad9363_pkg;

  localparam int unsigned TAP_COUNT = 32;
  localparam int unsigned TAP_W     = 5;
  localparam int unsigned LEN_W     = 6;

  typedef enum logic [3:0] {
    IDLE,
    CE_WAIT,
    SET_TAP,
    LOAD,
    SETTLE,
    CHECK,
    EVAL,
    FINAL,
    APPLY_SET,
    APPLY_LOAD,
    DONE,
    FAIL
  } cal_state_e;

  // Midpoint of a window, biased toward its start for even widths.
  function automatic logic [TAP_W-1:0] window_center(input logic [TAP_W-1:0] start,
                                                      input logic [LEN_W-1:0] len);
    logic [LEN_W-1:0] sum;
    sum = {1'b0, start} + ((len - LEN_W'(1)) >> 1);
    return sum[TAP_W-1:0];
  endfunction

endpackage

// File: rtl/ad9363_sync_bit.sv
// Two-flop synchronizer for a single level signal from a foreign domain.
module ad9363_sync_bit (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ad9363_rx_delay_cal.sv
// Sweeps all IDELAY taps, finds the widest window where rx_status holds, and
// loads the centre tap of that window back into the receive interface.
module ad9363_rx_delay_cal
  import ad9363_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 64,
  parameter int unsigned CHECK_CYCLES  = 1024,
  parameter int unsigned MIN_WINDOW    = 4
) (
  input  logic             ref_clk,
  input  logic             rst,
  input  logic             cal_start,
  input  logic             rx_status,
  output logic             data_clk_ce,
  output logic [TAP_W-1:0] rx_delay_value,
  output logic             rx_delay_load_en,
  output logic             cal_busy,
  output logic             cal_done,
  output logic             cal_fail,
  output logic [TAP_W-1:0] best_start,
  output logic [LEN_W-1:0] best_len
);

  localparam int unsigned CNT_MAX = (SETTLE_CYCLES > CHECK_CYCLES) ? SETTLE_CYCLES : CHECK_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CHECK_LAST  = CNT_W'(CHECK_CYCLES - 1);
  localparam logic [TAP_W-1:0] LAST_TAP    = TAP_W'(TAP_COUNT - 1);

  cal_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [TAP_W-1:0] tap;
  logic             pass;
  logic [TAP_W-1:0] run_start;
  logic [LEN_W-1:0] run_len;
  logic             rx_sync;

  logic [LEN_W-1:0] cand_len;
  logic [TAP_W-1:0] cand_start;
  logic             take_best;

  ad9363_sync_bit u_sync (
    .clk (ref_clk),
    .rst (rst),
    .d   (rx_status),
    .q   (rx_sync)
  );

  // A run is judged when it ends on a failing tap or when the sweep runs out
  // at the last tap; strict '>' keeps the lowest-start window on ties.
  always_comb begin
    cand_len   = pass ? (run_len + LEN_W'(1)) : run_len;
    cand_start = (pass && run_len == '0) ? tap : run_start;
    take_best  = (!pass || tap == LAST_TAP) && (cand_len > best_len);
  end

  always_ff @(posedge ref_clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      cnt              <= '0;
      tap              <= '0;
      pass             <= 1'b0;
      run_start        <= '0;
      run_len          <= '0;
      data_clk_ce      <= 1'b0;
      rx_delay_value   <= '0;
      rx_delay_load_en <= 1'b0;
      cal_busy         <= 1'b0;
      cal_done         <= 1'b0;
      cal_fail         <= 1'b0;
      best_start       <= '0;
      best_len         <= '0;
    end else begin
      unique case (state)
        IDLE, DONE, FAIL: begin
          if (cal_start) begin
            cal_done    <= 1'b0;
            cal_fail    <= 1'b0;
            best_start  <= '0;
            best_len    <= '0;
            run_start   <= '0;
            run_len     <= '0;
            tap         <= '0;
            cnt         <= '0;
            cal_busy    <= 1'b1;
            data_clk_ce <= 1'b1;
            state       <= CE_WAIT;
          end
        end
        CE_WAIT: begin
          if (cnt == SETTLE_LAST) begin
            cnt            <= '0;
            rx_delay_value <= tap;
            state          <= SET_TAP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        SET_TAP: begin
          rx_delay_load_en <= 1'b1;
          state            <= LOAD;
        end
        LOAD: begin
          rx_delay_load_en <= 1'b0;
          cnt              <= '0;
          state            <= SETTLE;
        end
        SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            cnt   <= '0;
            pass  <= 1'b1;
            state <= CHECK;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        CHECK: begin
          if (!rx_sync) pass <= 1'b0;
          if (cnt == CHECK_LAST) begin
            cnt   <= '0;
            state <= EVAL;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        EVAL: begin
          if (take_best) begin
            best_start <= cand_start;
            best_len   <= cand_len;
          end
          run_start <= cand_start;
          run_len   <= pass ? cand_len : '0;
          if (tap == LAST_TAP) begin
            state <= FINAL;
          end else begin
            tap            <= tap + TAP_W'(1);
            rx_delay_value <= tap + TAP_W'(1);
            state          <= SET_TAP;
          end
        end
        FINAL: begin
          if (best_len >= LEN_W'(MIN_WINDOW)) begin
            rx_delay_value <= window_center(best_start, best_len);
          end else begin
            rx_delay_value <= '0;
            cal_fail       <= 1'b1;
          end
          state <= APPLY_SET;
        end
        APPLY_SET: begin
          rx_delay_load_en <= 1'b1;
          state            <= APPLY_LOAD;
        end
        APPLY_LOAD: begin
          rx_delay_load_en <= 1'b0;
          cal_busy         <= 1'b0;
          if (cal_fail) begin
            state <= FAIL;
          end else begin
            cal_done <= 1'b1;
            state    <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ad9363_rx_delay_cal.sv
// Directed bench: rx_status is modelled as a pass map over the applied tap.
module tb_ad9363_rx_delay_cal;

  logic       ref_clk = 1'b0;
  logic       rst = 1'b1;
  logic       cal_start = 1'b0;
  logic       rx_status;
  logic       data_clk_ce;
  logic [4:0] rx_delay_value;
  logic       rx_delay_load_en;
  logic       cal_busy;
  logic       cal_done;
  logic       cal_fail;
  logic [4:0] best_start;
  logic [5:0] best_len;

  logic [31:0] pass_map = '0;
  logic        glitch = 1'b0;

  int checks = 0;
  int errors = 0;
  int load_cnt = 0;
  logic [4:0] load_vals [0:1023];

  always #5 ref_clk = ~ref_clk;

  assign rx_status = pass_map[rx_delay_value] & ~glitch;

  ad9363_rx_delay_cal #(
    .SETTLE_CYCLES (8),
    .CHECK_CYCLES  (16),
    .MIN_WINDOW    (4)
  ) dut (
    .ref_clk          (ref_clk),
    .rst              (rst),
    .cal_start        (cal_start),
    .rx_status        (rx_status),
    .data_clk_ce      (data_clk_ce),
    .rx_delay_value   (rx_delay_value),
    .rx_delay_load_en (rx_delay_load_en),
    .cal_busy         (cal_busy),
    .cal_done         (cal_done),
    .cal_fail         (cal_fail),
    .best_start       (best_start),
    .best_len         (best_len)
  );

  always @(posedge ref_clk) begin
    if (rx_delay_load_en) begin
      load_vals[load_cnt % 1024] = rx_delay_value;
      load_cnt = load_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge ref_clk) cal_start = 1'b1;
    @(negedge ref_clk) cal_start = 1'b0;
  endtask

  task automatic wait_loads(input int target);
    int n = 0;
    while (load_cnt < target && n < 2000) begin
      @(negedge ref_clk);
      n++;
    end
    check("wait_loads_timeout", (load_cnt >= target) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (cal_busy && n < 3000) begin
      @(negedge ref_clk);
      n++;
    end
    check("wait_idle_timeout", {31'd0, cal_busy}, 32'd0);
  endtask

  // Checks that the 32 sweep strobes from base carry taps 0..31 in order.
  task automatic check_sweep(input string tag, input int base);
    int bad = 0;
    for (int i = 0; i < 32; i++)
      if (load_vals[(base + i) % 1024] !== 5'(i)) bad++;
    check(tag, bad, 32'd0);
  endtask

  initial begin
    int base;

    #2;
    check("reset_outputs", {data_clk_ce, rx_delay_value, rx_delay_load_en, cal_busy,
                            cal_done, cal_fail, best_start, best_len}, 32'd0);
    repeat (3) @(negedge ref_clk);
    rst = 1'b0;
    repeat (5) @(negedge ref_clk);
    check("idle_after_reset", {30'd0, cal_busy, data_clk_ce}, 32'd0);

    // Window 10..20
    pass_map = 32'h001F_FC00;
    base = load_cnt;
    pulse_start();
    check("busy_after_start", {31'd0, cal_busy}, 32'd1);
    wait_idle();
    check("w1_loads", load_cnt - base, 32'd33);
    check_sweep("w1_sweep", base);
    check("w1_best_start", best_start, 32'd10);
    check("w1_best_len", best_len, 32'd11);
    check("w1_applied", rx_delay_value, 32'd15);
    check("w1_last_strobe", load_vals[(base + 32) % 1024], 32'd15);
    check("w1_done_fail", {30'd0, cal_done, cal_fail}, 32'd2);
    check("w1_ce", {31'd0, data_clk_ce}, 32'd1);

    // Tied windows 2..5 and 20..23
    pass_map = 32'h00F0_003C;
    base = load_cnt;
    pulse_start();
    wait_idle();
    check("w2_best_start", best_start, 32'd2);
    check("w2_best_len", best_len, 32'd4);
    check("w2_applied", rx_delay_value, 32'd3);
    check("w2_done_fail", {30'd0, cal_done, cal_fail}, 32'd2);

    // Window ending at the last tap
    pass_map = 32'hF000_0000;
    pulse_start();
    wait_idle();
    check("w3_best_start", best_start, 32'd28);
    check("w3_best_len", best_len, 32'd4);
    check("w3_applied", rx_delay_value, 32'd29);

    // Window too narrow
    pass_map = 32'h0000_01C0;
    pulse_start();
    wait_idle();
    check("w4_best_len", best_len, 32'd3);
    check("w4_applied", rx_delay_value, 32'd0);
    check("w4_done_fail", {30'd0, cal_done, cal_fail}, 32'd1);
    repeat (4) @(negedge ref_clk);
    check("w4_fail_stable", {best_len, 5'd0, best_start}, {6'd3, 5'd0, 5'd6});

    // Glitch inside tap 12 check window
    pass_map = 32'h001F_FC00;
    base = load_cnt;
    pulse_start();
    wait_loads(base + 13);
    repeat (12) @(negedge ref_clk);
    glitch = 1'b1;
    @(negedge ref_clk) glitch = 1'b0;
    wait_idle();
    check("w5_best_start", best_start, 32'd13);
    check("w5_best_len", best_len, 32'd8);
    check("w5_applied", rx_delay_value, 32'd16);
    check("w5_done", {31'd0, cal_done}, 32'd1);

    // Reset during tap 7 settle
    base = load_cnt;
    pulse_start();
    wait_loads(base + 8);
    repeat (3) @(negedge ref_clk);
    #2 rst = 1'b1;
    #1;
    check("midreset_outputs", {data_clk_ce, rx_delay_value, rx_delay_load_en, cal_busy,
                               cal_done, cal_fail, best_start, best_len}, 32'd0);
    @(negedge ref_clk) rst = 1'b0;
    repeat (6) @(negedge ref_clk);
    check("midreset_stays_idle", {30'd0, cal_busy, data_clk_ce}, 32'd0);

    // Fresh sweep with a cal_start issued mid-sweep
    base = load_cnt;
    pulse_start();
    wait_loads(base + 6);
    pulse_start();
    wait_idle();
    check("w6_first_tap", load_vals[base % 1024], 32'd0);
    check("w6_loads", load_cnt - base, 32'd33);
    check_sweep("w6_sweep", base);
    check("w6_best", {best_len, 5'd0, best_start}, {6'd11, 5'd0, 5'd10});
    check("w6_applied", rx_delay_value, 32'd15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ad9363_rx_delay_cal.md
AD9363_RX_DELAY_CAL -- requirements
Module: ad9363_rx_delay_cal

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 64: ref_clk cycles waited after each delay load before sampling; legal minimum 4.
REQ-002 SHALL have parameter CHECK_CYCLES, default 1024: ref_clk cycles rx_status is sampled per tap.
REQ-003 SHALL have parameter MIN_WINDOW, default 4: minimum passing-window width in taps for success.
REQ-004 SHALL have ports, in this order:
 - ref_clk  in  1  sole clock, free-running 200 MHz.
 - rst  in  1  asynchronous, active-high reset.
 - cal_start  in  1  one-cycle request to begin calibration.
 - rx_status  in  1  receive-integrity flag from the CMOS receive interface (foreign domain).
 - data_clk_ce  out  1  receive clock enable to the interface.
 - rx_delay_value  out  5  IDELAY tap to the interface.
 - rx_delay_load_en  out  1  tap load strobe.
 - cal_busy  out  1  sweep in progress.
 - cal_done  out  1  calibration succeeded (sticky).
 - cal_fail  out  1  calibration failed (sticky).
 - best_start  out  5  first tap of widest passing window.
 - best_len  out  6  width of widest passing window, 0..32.

Function
REQ-005 SHALL pass rx_status through a 2-flop synchronizer; all pass/fail decisions use the synchronized value.
REQ-006 SHALL implement states IDLE, CE_WAIT, SET_TAP, LOAD, SETTLE, CHECK, EVAL, FINAL, APPLY_SET, APPLY_LOAD, DONE, FAIL.
REQ-007 IDLE/DONE/FAIL + cal_start -> CE_WAIT; clear cal_done, cal_fail, best_start, best_len, run tracking; tap := 0; cal_busy := 1.
REQ-008 cal_start in any other state SHALL be ignored.
REQ-009 CE_WAIT: data_clk_ce := 1 (remains 1 until reset); wait SETTLE_CYCLES -> SET_TAP.
REQ-010 SET_TAP: rx_delay_value := tap, held for one cycle, -> LOAD.
REQ-011 LOAD: rx_delay_load_en = 1 for exactly one cycle, rx_delay_value unchanged -> SETTLE.
REQ-012 SETTLE: wait SETTLE_CYCLES -> CHECK with pass flag := 1.
REQ-013 CHECK: for CHECK_CYCLES cycles, any sampled synchronized rx_status = 0 clears pass flag; then -> EVAL.
REQ-014 EVAL: pass extends current run (run_start := tap if run length was 0); a fail ends the run; a run ending by fail or at tap 31 SHALL replace best only if strictly longer (ties keep lowest start).
REQ-015 EVAL: tap < 31 -> tap+1, SET_TAP; tap = 31 -> FINAL.
REQ-016 FINAL: best_len >= MIN_WINDOW -> center := best_start + floor((best_len-1)/2), -> APPLY_SET; else center := 0, cal_fail := 1, -> APPLY_SET.
REQ-017 APPLY_SET/APPLY_LOAD SHALL reuse REQ-010/011 timing with center; then -> DONE (cal_done := 1) or FAIL per REQ-016.
REQ-018 cal_busy SHALL be 1 in every state except IDLE, DONE, FAIL.
REQ-019 best_start/best_len SHALL update only in EVAL and remain stable in DONE/FAIL.
REQ-020 Counters SHALL be sized for max(SETTLE_CYCLES, CHECK_CYCLES); tap arithmetic SHALL never wrap past 31.

Reset
REQ-021 rst SHALL asynchronously force IDLE, all outputs 0, synchronizer flops 0, counters/run tracking 0, including mid-sweep.
REQ-022 After rst deasserts the block SHALL stay in IDLE until cal_start.

Structure
REQ-023 State encoding, TAP_COUNT = 32 and TAP_W = 5 SHALL live in shared package ad9363_pkg.
REQ-024 The synchronizer SHALL be sub-module ad9363_sync_bit (2 flops, async reset to 0).

Verification (SETTLE_CYCLES=8, CHECK_CYCLES=16, MIN_WINDOW=4)
REQ-025 rx_status passing taps 10..20 only -> best_start=10, best_len=11, final rx_delay_value=15, cal_done=1, cal_fail=0, exactly 33 load strobes.
REQ-026 Passing taps 2..5 and 20..23 (tie) -> best_start=2, best_len=4, applied tap 3, cal_done=1.
REQ-027 Passing taps 28..31 (run ends at tap 31) -> best_start=28, best_len=4, applied tap 29.
REQ-028 Passing taps 6..8 only -> best_len=3, cal_fail=1, cal_done=0, applied tap 0.
REQ-029 Single-cycle rx_status glitch low inside tap 12 CHECK, otherwise pass 10..20 -> tap 12 fails, best_start=13, best_len=8, applied tap 16.
REQ-030 rst asserted during tap 7 SETTLE; cal_start re-issued mid-sweep -> all outputs 0 immediately; mid-sweep cal_start has no effect; new sweep starts from tap 0.
